// File: rtl/mult_seq_ctrl.sv
// Sequential radix-2 shift-add unsigned multiplier driven by the decoder's one-hot cmd bus.
// One operand bit per cycle; stalls fetch while running and pulses done with the full product.
`timescale 1ns/1ps
module mult_seq_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_vld,
  input  logic [7:0]           cmd,
  input  logic [WIDTH-1:0]     opa,
  input  logic [WIDTH-1:0]     opb,
  output logic                 busy,
  output logic                 stall,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 cmd_err
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             onehot;
  logic             go;
  logic             last;
  logic             bad_cmd;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] b_nx;

  assign onehot  = (cmd != 8'd0) && ((cmd & (cmd - 8'd1)) == 8'd0);
  assign bad_cmd = instr_vld && (cmd != 8'd0) && !onehot;
  assign go      = instr_vld && onehot && cmd[0] && (state == IDLE);
  assign last    = (cnt_q == CNT_W'(1));
  assign stall   = go | busy;

  // One shift-add step; the carry out of the add becomes the new accumulator MSB.
  always_comb begin
    sum    = {1'b0, acc_q} + (b_q[0] ? {1'b0, a_q} : (WIDTH + 1)'(0));
    acc_nx = sum[WIDTH:1];
    b_nx   = {sum[0], b_q[WIDTH-1:1]};
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (go) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      state   <= state_nx;
      busy    <= (state_nx != IDLE);
      done    <= (state_nx == DONE);
      cmd_err <= bad_cmd;
    end
  end

  // Datapath: operands latched on accept, product only written on the final step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      product <= '0;
    end else if (go) begin
      a_q   <= opa;
      b_q   <= opb;
      acc_q <= '0;
      cnt_q <= CNT_W'(WIDTH);
    end else if (state == RUN) begin
      acc_q <= acc_nx;
      b_q   <= b_nx;
      cnt_q <= cnt_q - CNT_W'(1);
      if (last) product <= {acc_nx, b_nx};
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: directed scenarios plus random traffic against an arithmetic model.
`timescale 1ns/1ps
module tb_mult_seq_ctrl;

  localparam int unsigned W = 8;

  logic          clk;
  logic          rst_n;
  logic          instr_vld;
  logic [7:0]    cmd;
  logic [W-1:0]  opa;
  logic [W-1:0]  opb;
  logic          busy;
  logic          stall;
  logic          done;
  logic [2*W-1:0] product;
  logic          cmd_err;

  int n_vec;
  int n_err;

  mult_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .instr_vld (instr_vld),
    .cmd       (cmd),
    .opa       (opa),
    .opb       (opb),
    .busy      (busy),
    .stall     (stall),
    .done      (done),
    .product   (product),
    .cmd_err   (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Multiply a*b; inj_at (1..W+1) re-issues MULTIPLY with junk operands that must be ignored.
  task automatic mul_txn(input logic [7:0] a, input logic [7:0] b, input int inj_at);
    int lat;
    int dones;
    int errs;
    lat = 0; dones = 0; errs = 0;
    instr_vld = 1'b1; cmd = 8'h01; opa = a; opb = b;
    #1 chk("stall_on_go", 32'(stall), 32'd1);
    step();
    chk("busy_after_accept", 32'(busy), 32'd1);
    for (int i = 1; i <= int'(W) + 2; i++) begin
      if (i == inj_at) begin
        instr_vld = 1'b1; cmd = 8'h01; opa = 8'($urandom); opb = 8'($urandom);
      end else begin
        instr_vld = 1'b0; cmd = 8'($urandom); opa = 8'($urandom); opb = 8'($urandom);
      end
      step();
      if (done) begin
        dones++;
        if (lat == 0) lat = i;
      end
      if (cmd_err) errs++;
      if (i == 3) chk("stall_in_run", 32'(stall), 32'd1);
      if (i == int'(W) + 1) chk("busy_low_after_done", 32'(busy), 32'd0);
    end
    chk("done_latency", 32'(lat), 32'(W));
    chk("done_count", 32'(dones), 32'd1);
    chk("no_cmd_err", 32'(errs), 32'd0);
    chk("product", 32'(product), 32'(a) * 32'(b));
    chk("done_dropped", 32'(done), 32'd0);
  endtask

  // One idle-cycle command that must never start a multiply; err predicted from bit count.
  task automatic idle_cmd(input logic vld, input logic [7:0] c);
    logic err_exp;
    err_exp = vld && (c != 8'd0) && ($countones(c) != 1);
    instr_vld = vld; cmd = c; opa = 8'($urandom); opb = 8'($urandom);
    #1 chk("stall_no_go", 32'(stall), 32'd0);
    step();
    chk("cmd_err", 32'(cmd_err), 32'(err_exp));
    chk("busy_stays_idle", 32'(busy), 32'd0);
    instr_vld = 1'b0; cmd = 8'h00;
    step();
    chk("cmd_err_pulse_end", 32'(cmd_err), 32'd0);
    chk("no_done", 32'(done), 32'd0);
  endtask

  initial begin
    int d1;
    int d2;
    int cnt;
    logic [7:0] c;
    logic [7:0] a2;
    logic [7:0] b2;
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; instr_vld = 1'b0; cmd = 8'h00; opa = '0; opb = '0;
    repeat (2) step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    chk("rst_cmd_err", 32'(cmd_err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    rst_n = 1'b1;
    step();

    mul_txn(8'd13, 8'd11, 0);
    chk("p_13x11", 32'(product), 32'h008F);
    mul_txn(8'd255, 8'd255, 0);
    chk("p_255x255", 32'(product), 32'hFE01);
    mul_txn(8'd0, 8'd200, 0);
    mul_txn(8'd57, 8'd99, 3);

    idle_cmd(1'b1, 8'h03);
    idle_cmd(1'b1, 8'h04);
    idle_cmd(1'b1, 8'h00);
    idle_cmd(1'b0, 8'h03);
    idle_cmd(1'b1, 8'hFF);

    // Reset mid-run: outputs clear asynchronously and the aborted result never appears.
    instr_vld = 1'b1; cmd = 8'h01; opa = 8'd200; opb = 8'd3;
    step();
    instr_vld = 1'b0; cmd = 8'h00;
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_done", 32'(done), 32'd0);
    chk("async_product", 32'(product), 32'd0);
    chk("async_stall", 32'(stall), 32'd0);
    step();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) cnt++;
    end
    chk("no_done_after_reset", 32'(cnt), 32'd0);
    chk("product_still_zero", 32'(product), 32'd0);
    mul_txn(8'd7, 8'd9, 0);
    chk("p_7x9", 32'(product), 32'h003F);

    // Upstream holds the next MULTIPLY under stall; it is taken once the unit is idle again.
    a2 = 8'd173; b2 = 8'd46;
    instr_vld = 1'b1; cmd = 8'h01; opa = 8'd91; opb = 8'd222;
    step();
    opa = a2; opb = b2;
    d1 = 0; d2 = 0;
    for (int i = 1; i <= 2 * int'(W) + 6; i++) begin
      step();
      if (done) begin
        if (d1 == 0) begin
          d1 = i;
          chk("b2b_first", 32'(product), 32'd91 * 32'd222);
        end else begin
          d2 = i;
          chk("b2b_second", 32'(product), 32'(a2) * 32'(b2));
        end
      end
      if (i == int'(W) + 1) begin
        chk("b2b_busy_fell", 32'(busy), 32'd0);
        chk("b2b_stall_go", 32'(stall), 32'd1);
      end
      if (i == int'(W) + 2) begin
        chk("b2b_accepted", 32'(busy), 32'd1);
        instr_vld = 1'b0; cmd = 8'h00;
      end
    end
    chk("b2b_first_lat", 32'(d1), 32'(W));
    chk("b2b_spacing", 32'(d2 - d1), 32'(W + 2));

    // Random traffic: operands, corner values, in-run re-issue and idle command noise.
    for (int t = 0; t < 40; t++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 5) == 0) ra = 8'hFF;
      if ($urandom_range(0, 5) == 0) rb = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      mul_txn(ra, rb, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, W + 1)) : 0);
      c = 8'($urandom);
      if (c == 8'h01) c = 8'h02;
      idle_cmd(1'($urandom), c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
